// File: rtl/cache_ctrl.sv
// Cache line controller: hit/miss handling, dirty writeback and refill sequencing.
// Define CACHE_CTRL_STATS_EN to add the saturating hit_count/miss_count outputs.
module cache_ctrl #(
  parameter int TAG           = 20,
  parameter int WORD_SIZE_BIT = 32,
  parameter int DATA_BLOCK    = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [1:0] cpu_word,
  input  logic       tag_eq,
  input  logic       line_valid,
  input  logic       line_dirty,
  output logic       cpu_ready,
  output logic       data_oe,
  output logic [1:0] word_sel,
  output logic       word_we,
  output logic       line_we,
  output logic       set_dirty,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  // The 2-bit word select only covers a line of exactly four words.
  if (DATA_BLOCK != 4 * WORD_SIZE_BIT || TAG < 1) begin : g_param_check
    $error("cache_ctrl: DATA_BLOCK must hold four WORD_SIZE_BIT words and TAG must be non-zero");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    REFILL    = 3'd4
  } state_t;

  state_t     state, state_next;
  logic       we_q;
  logic [1:0] word_q;
  logic       hit;

  assign hit      = tag_eq & line_valid;
  assign word_sel = word_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      word_q <= 2'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && cpu_req) begin
        we_q   <= cpu_we;
        word_q <= cpu_word;
      end
    end
  end

  always_comb begin
    state_next = state;
    cpu_ready  = 1'b0;
    data_oe    = 1'b0;
    word_we    = 1'b0;
    line_we    = 1'b0;
    set_dirty  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          data_oe    = ~we_q;
          word_we    = we_q;
          set_dirty  = we_q;
          state_next = IDLE;
        end else if (line_valid && line_dirty) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        data_oe = 1'b1;
        if (mem_ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          line_we    = 1'b1;
          state_next = REFILL;
        end
      end
      REFILL: begin
        state_next = COMPARE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // The COMPARE pass that follows a refill is the same request again, so its hit is not counted.
  logic retry;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retry      <= 1'b0;
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      if (state == REFILL)
        retry <= 1'b1;
      else if (state == IDLE)
        retry <= 1'b0;
      if (state == COMPARE) begin
        if (hit && !retry && hit_count != 16'hFFFF)
          hit_count <= hit_count + 16'd1;
        if (!hit && miss_count != 16'hFFFF)
          miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed cycle tables plus randomized transactions
// expanded into expected per-cycle traces by a transaction-level model.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, cpu_req, cpu_we, tag_eq, line_valid, line_dirty, mem_ready;
  logic [1:0] cpu_word;
  logic       cpu_ready, data_oe, word_we, line_we, set_dirty, mem_req, mem_we;
  logic [1:0] word_sel;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_word   (cpu_word),
    .tag_eq     (tag_eq),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .cpu_ready  (cpu_ready),
    .data_oe    (data_oe),
    .word_sel   (word_sel),
    .word_we    (word_we),
    .line_we    (line_we),
    .set_dirty  (set_dirty),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs for one cycle: {rst_n, req, we, word[1:0], tag_eq, valid, dirty, mem_ready}
  typedef struct packed {
    logic       rst_n, req, we;
    logic [1:0] word;
    logic       te, lv, ld, mr;
  } ins_t;

  // Expected outputs: {ready, oe, wsel[1:0], word_we, line_we, set_dirty, mem_req, mem_we}
  typedef struct packed {
    logic       ready, oe;
    logic [1:0] wsel;
    logic       wwe, lwe, sd, mreq, mwe;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
    string name;
  } step_t;

  step_t      plan[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] mWord;
  int         mHits, mMisses;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rw();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic ins_t mkIn(input logic rst_n, req, we, input logic [1:0] word,
                                input logic te, lv, ld, mr);
    return '{rst_n, req, we, word, te, lv, ld, mr};
  endfunction

  function automatic outs_t o(input logic ready, oe, input logic [1:0] wsel,
                              input logic wwe, lwe, sd, mreq, mwe);
    return '{ready, oe, wsel, wwe, lwe, sd, mreq, mwe};
  endfunction

  function automatic outs_t hitOuts(input logic we, input logic [1:0] word);
    return o(1'b1, !we, word, we, 1'b0, we, 1'b0, 1'b0);
  endfunction

  task automatic addStep(input ins_t in, input outs_t exp, input string name);
    step_t s;
    s.in   = in;
    s.exp  = exp;
    s.name = name;
    plan.push_back(s);
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++)
      addStep(mkIn(1'b1, 1'b0, rb(), rw(), rb(), rb(), rb(), rb()),
              o(1'b0, 1'b0, mWord, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "idle");
  endtask

  // Reset lands during a memory cycle: that cycle still shows the busy outputs,
  // the next is idle with everything cleared and a stray mem_ready ignored.
  task automatic addAbort(input outs_t e, input logic mr);
    addStep(mkIn(1'b0, rb(), rb(), rw(), rb(), rb(), rb(), mr), e, "abort");
    addStep(mkIn(1'b1, 1'b0, rb(), rw(), rb(), rb(), rb(), 1'b1),
            o(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "post_reset");
    mWord   = 2'd0;
    mHits   = 0;
    mMisses = 0;
  endtask

  // kind: 0 hit, 1 clean miss, 2 dirty miss, 3 invalid line. abortAt picks a memory cycle (1-based) to reset in.
  task automatic addTxn(input logic we, input logic [1:0] word, input int kind,
                        input int wbLat, input int alLat, input int abortAt);
    int    memIdx;
    logic  te, lv, ld, mr;
    outs_t e;
    memIdx = 0;
    addStep(mkIn(1'b1, 1'b1, we, word, rb(), rb(), rb(), rb()),
            o(1'b0, 1'b0, mWord, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "accept");
    mWord = word;
    if (kind == 0) begin
      addStep(mkIn(1'b1, rb(), rb(), rw(), 1'b1, 1'b1, rb(), rb()), hitOuts(we, word), "hit");
      if (mHits < 65535) mHits++;
      return;
    end
    case (kind)
      1:       begin te = 1'b0; lv = 1'b1; ld = 1'b0; end
      2:       begin te = 1'b0; lv = 1'b1; ld = 1'b1; end
      default: begin te = rb(); lv = 1'b0; ld = rb(); end
    endcase
    addStep(mkIn(1'b1, rb(), rb(), rw(), te, lv, ld, rb()),
            o(1'b0, 1'b0, word, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "miss");
    if (mMisses < 65535) mMisses++;
    if (kind == 2) begin
      for (int i = 0; i < wbLat; i++) begin
        mr = (i == wbLat - 1);
        e  = o(1'b0, 1'b1, word, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        memIdx++;
        if (memIdx == abortAt) begin addAbort(e, mr); return; end
        addStep(mkIn(1'b1, rb(), rb(), rw(), rb(), rb(), rb(), mr), e, "writeback");
      end
    end
    for (int i = 0; i < alLat; i++) begin
      mr = (i == alLat - 1);
      e  = o(1'b0, 1'b0, word, 1'b0, mr, 1'b0, 1'b1, 1'b0);
      memIdx++;
      if (memIdx == abortAt) begin addAbort(e, mr); return; end
      addStep(mkIn(1'b1, rb(), rb(), rw(), rb(), rb(), rb(), mr), e, "allocate");
    end
    addStep(mkIn(1'b1, rb(), rb(), rw(), rb(), rb(), rb(), rb()),
            o(1'b0, 1'b0, word, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "refill");
    addStep(mkIn(1'b1, rb(), rb(), rw(), 1'b1, 1'b1, rb(), rb()), hitOuts(we, word), "retry");
  endtask

  task automatic applyStimulus(input step_t s);
    reset_n    = s.in.rst_n;
    cpu_req    = s.in.req;
    cpu_we     = s.in.we;
    cpu_word   = s.in.word;
    tag_eq     = s.in.te;
    line_valid = s.in.lv;
    line_dirty = s.in.ld;
    mem_ready  = s.in.mr;
  endtask

  task automatic checkOutput(input step_t s, input int idx);
    outs_t got;
    #2;
    got = '{cpu_ready, data_oe, word_sel, word_we, line_we, set_dirty, mem_req, mem_we};
    checks++;
    if (got !== s.exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %b expected %b", s.name, idx, got, s.exp);
    end
  endtask

  task automatic runPlan();
    for (int i = 0; i < plan.size(); i++) begin
      applyStimulus(plan[i]);
      checkOutput(plan[i], i);
      @(posedge clk);
      #1;
    end
    plan.delete();
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic checkStats(input int h, input int m);
    checks++;
    if (hit_count !== 16'(h) || miss_count !== 16'(m)) begin
      errors++;
      $display("[TB] FAIL stats: got hits=%0d misses=%0d expected hits=%0d misses=%0d",
               hit_count, miss_count, h, m);
    end
  endtask
`endif

  initial begin
    int kind, wbLat, alLat, abortAt;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_word = 2'd0;
    tag_eq = 1'b0; line_valid = 1'b0; line_dirty = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_00_0_0_0_0_0, "reset_state");
    // read hit, word 2
    addStep(9'b1_1_0_10_0_0_0_1, 9'b0_0_00_0_0_0_0_0, "rh_accept");
    addStep(9'b1_1_0_10_1_1_0_0, 9'b1_1_10_0_0_0_0_0, "rh_compare");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_10_0_0_0_0_0, "rh_idle");
    // write hit, word 3; request dropped and inputs changed during compare
    addStep(9'b1_1_1_11_0_0_0_0, 9'b0_0_10_0_0_0_0_0, "wh_accept");
    addStep(9'b1_0_0_01_1_1_1_0, 9'b1_0_11_1_0_1_0_0, "wh_compare");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_11_0_0_0_0_0, "wh_idle");
    // clean read miss, word 1, memory answers after 4 cycles
    addStep(9'b1_1_0_01_0_0_0_0, 9'b0_0_11_0_0_0_0_0, "cm_accept");
    addStep(9'b1_1_0_01_0_1_0_0, 9'b0_0_01_0_0_0_0_0, "cm_compare");
    addStep(9'b1_1_0_01_0_1_0_0, 9'b0_0_01_0_0_0_1_0, "cm_alloc1");
    addStep(9'b1_1_0_01_0_1_0_0, 9'b0_0_01_0_0_0_1_0, "cm_alloc2");
    addStep(9'b1_1_0_01_0_1_0_0, 9'b0_0_01_0_0_0_1_0, "cm_alloc3");
    addStep(9'b1_1_0_01_0_1_0_1, 9'b0_0_01_0_1_0_1_0, "cm_alloc4");
    addStep(9'b1_1_0_01_0_1_0_1, 9'b0_0_01_0_0_0_0_0, "cm_refill");
    addStep(9'b1_1_0_01_1_1_0_0, 9'b1_1_01_0_0_0_0_0, "cm_retry");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_01_0_0_0_0_0, "cm_idle");
    // dirty write miss, word 0
    addStep(9'b1_1_1_00_0_1_1_0, 9'b0_0_01_0_0_0_0_0, "dm_accept");
    addStep(9'b1_1_1_00_0_1_1_0, 9'b0_0_00_0_0_0_0_0, "dm_compare");
    addStep(9'b1_1_1_00_0_1_1_0, 9'b0_1_00_0_0_0_1_1, "dm_wb1");
    addStep(9'b1_1_1_00_0_1_1_1, 9'b0_1_00_0_0_0_1_1, "dm_wb2");
    addStep(9'b1_1_1_00_0_1_1_1, 9'b0_0_00_0_1_0_1_0, "dm_alloc");
    addStep(9'b1_1_1_00_0_1_1_0, 9'b0_0_00_0_0_0_0_0, "dm_refill");
    addStep(9'b1_1_1_00_1_1_1_0, 9'b1_0_00_1_0_1_0_0, "dm_retry");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_00_0_0_0_0_0, "dm_idle");
    // reset mid-allocate, then a stray mem_ready
    addStep(9'b1_1_0_10_0_0_0_0, 9'b0_0_00_0_0_0_0_0, "ra_accept");
    addStep(9'b1_1_0_10_0_0_0_0, 9'b0_0_10_0_0_0_0_0, "ra_compare");
    addStep(9'b1_1_0_10_0_0_0_0, 9'b0_0_10_0_0_0_1_0, "ra_alloc");
    addStep(9'b0_1_0_10_0_0_0_0, 9'b0_0_10_0_0_0_1_0, "ra_alloc_reset");
    addStep(9'b1_0_0_00_0_0_0_1, 9'b0_0_00_0_0_0_0_0, "ra_after_reset");
    addStep(9'b1_0_0_00_0_0_0_1, 9'b0_0_00_0_0_0_0_0, "ra_stray");
    // a request held during reset is not taken until reset_n is high
    addStep(9'b0_1_1_11_1_1_0_0, 9'b0_0_00_0_0_0_0_0, "ri_hold");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_00_0_0_0_0_0, "ri_after");
    addStep(9'b1_1_0_01_0_0_0_0, 9'b0_0_00_0_0_0_0_0, "ri_accept");
    addStep(9'b1_1_0_01_1_1_0_0, 9'b1_1_01_0_0_0_0_0, "ri_compare");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_01_0_0_0_0_0, "ri_idle");
    addStep(9'b0_0_0_00_0_0_0_0, 9'b0_0_01_0_0_0_0_0, "stats_reset");
    addStep(9'b1_0_0_00_0_0_0_0, 9'b0_0_00_0_0_0_0_0, "stats_idle");
    mWord = 2'd0; mHits = 0; mMisses = 0;
    for (int i = 0; i < 3; i++) addTxn(1'b0, rw(), 0, 0, 0, 0);
    addTxn(1'b0, rw(), 1, 0, 4, 0);
    addIdle(1);
    runPlan();
`ifdef CACHE_CTRL_STATS_EN
    checkStats(3, 1);
`endif

    for (int t = 0; t < 80; t++) begin
      kind    = $urandom_range(0, 3);
      wbLat   = $urandom_range(1, 5);
      alLat   = $urandom_range(1, 5);
      abortAt = 0;
      if (kind != 0 && $urandom_range(0, 5) == 0)
        abortAt = $urandom_range(1, (kind == 2 ? wbLat : 0) + alLat);
      addTxn(rb(), rw(), kind, wbLat, alLat, abortAt);
      addIdle($urandom_range(0, 2));
    end
    addIdle(1);
    runPlan();
`ifdef CACHE_CTRL_STATS_EN
    checkStats(mHits, mMisses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
